// File: rtl/dl_reg_wr_arb.sv
// Round-robin write arbiter that shares the write port of one NUM_BITS register among NUM_REQ sources.
// Optional DL_REG_WR_ARB_LOCK_EN adds a lock input that lets the granted source keep top priority.
module dl_reg_wr_arb #(
  parameter int unsigned          NUM_REQ   = 4,
  parameter int unsigned          NUM_BITS  = 32,
  parameter logic [NUM_BITS-1:0]  RESET_VAL = '0,
  localparam int unsigned         SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  wdata,
`ifdef DL_REG_WR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           lock,
`endif
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_BITS-1:0]          q,
  output logic                         upd,
  output logic [SRC_W-1:0]             last_src
);

  logic [SRC_W-1:0]    ptr;
  logic [SRC_W-1:0]    ptr_eff;
  logic [SRC_W-1:0]    sel;
  logic [SRC_W-1:0]    ptr_nxt;
  logic                any;
  logic [NUM_BITS-1:0] slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = wdata[i*NUM_BITS +: NUM_BITS];
  end

  // An out-of-range pointer is treated as requester 0.
  assign ptr_eff = (32'(ptr) >= NUM_REQ) ? '0 : ptr;

  always_comb begin
    int unsigned idx;
    idx = 0;
    gnt = '0;
    sel = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_eff) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[SRC_W'(idx)]) begin
        any                 = 1'b1;
        sel                 = SRC_W'(idx);
        gnt[SRC_W'(idx)]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
`ifdef DL_REG_WR_ARB_LOCK_EN
    if (lock[sel]) ptr_nxt = sel;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RESET_VAL;
      ptr      <= '0;
      upd      <= 1'b0;
      last_src <= '0;
    end else begin
      upd <= any;
      if (any) begin
        q        <= slot[sel];
        last_src <= sel;
        ptr      <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dl_reg_wr_arb.sv
// Scoreboard bench for dl_reg_wr_arb: a 4-requester instance with non-zero reset value and a 3-requester instance.
`timescale 1ns/1ps
module tb_dl_reg_wr_arb;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;
`ifdef DL_REG_WR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    int          src;
    logic        upd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req_a = '0;
  logic [3:0]   gnt_a;
  logic [31:0]  wd_a [4];
  logic [127:0] wdata_a;
  logic [31:0]  q_a;
  logic         upd_a;
  logic [1:0]   src_a;

  logic [2:0]   req_b = '0;
  logic [2:0]   gnt_b;
  logic [31:0]  wd_b [3];
  logic [95:0]  wdata_b;
  logic [31:0]  q_b;
  logic         upd_b;
  logic [1:0]   src_b;

`ifdef DL_REG_WR_ARB_LOCK_EN
  logic [3:0]   lock_a = '0;
  logic [2:0]   lock_b = '0;
`endif

  assign wdata_a = {wd_a[3], wd_a[2], wd_a[1], wd_a[0]};
  assign wdata_b = {wd_b[2], wd_b[1], wd_b[0]};

  dl_reg_wr_arb #(.NUM_REQ(4), .NUM_BITS(32), .RESET_VAL(RV)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a),
`ifdef DL_REG_WR_ARB_LOCK_EN
    .lock(lock_a),
`endif
    .gnt(gnt_a), .q(q_a), .upd(upd_a), .last_src(src_a));

  dl_reg_wr_arb #(.NUM_REQ(3), .NUM_BITS(32), .RESET_VAL(32'h0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b),
`ifdef DL_REG_WR_ARB_LOCK_EN
    .lock(lock_b),
`endif
    .gnt(gnt_b), .q(q_b), .upd(upd_b), .last_src(src_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference arbiter: first set request bit scanning from p with modulo wrap.
  function automatic int pick(input logic [7:0] r, input int p, input int n);
    int s;
    s = (p >= n) ? 0 : p;
    for (int k = 0; k < n; k++)
      if (((r >> ((s + k) % n)) & 8'd1) != 8'd0) return (s + k) % n;
    return -1;
  endfunction

  int          ptr_a = 0;
  logic [31:0] mq_a  = RV;
  int          msrc_a = 0;
  exp_t        sb_a [$];

  int          ptr_b = 0;
  logic [31:0] mq_b  = '0;
  int          msrc_b = 0;
  exp_t        sb_b [$];

  task automatic rnd_a();
    for (int i = 0; i < 4; i++) wd_a[i] = $urandom;
  endtask

  task automatic cyc_a(input logic [3:0] r, input logic [3:0] lk);
    int         g;
    logic [1:0] gi;
    exp_t       e;
    req_a = r;
`ifdef DL_REG_WR_ARB_LOCK_EN
    lock_a = lk;
`endif
    @(negedge clk);
    g  = pick({4'b0, r}, ptr_a, 4);
    gi = g[1:0];
    chk("gnt_a", 64'(gnt_a), (g >= 0) ? 64'(4'(32'd1 << g)) : 64'd0);
    if (g >= 0) begin
      mq_a   = wd_a[gi];
      msrc_a = g;
      ptr_a  = (LOCK && lk[gi]) ? g : (g + 1) % 4;
    end
    sb_a.push_back('{mq_a, msrc_a, g >= 0});
    @(posedge clk); #1;
    e = sb_a.pop_front();
    chk("q_a", 64'(q_a), 64'(e.q));
    chk("src_a", 64'(src_a), 64'(e.src));
    chk("upd_a", 64'(upd_a), 64'(e.upd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   g;
    for (int i = 0; i < 4; i++) wd_a[i] = '0;
    for (int i = 0; i < 3; i++) wd_b[i] = '0;

    #12;
    chk("rst_q_a", 64'(q_a), 64'(RV));
    chk("rst_upd_a", 64'(upd_a), 64'd0);
    chk("rst_src_a", 64'(src_a), 64'd0);
    chk("rst_q_b", 64'(q_b), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester, then idle hold
    rnd_a();
    wd_a[2] = 32'h1234;
    cyc_a(4'b0100, 4'b0000);
    chk("single_q", 64'(q_a), 64'h1234);
    chk("single_src", 64'(src_a), 64'd2);
    cyc_a(4'b0000, 4'b0000);
    chk("idle_q", 64'(q_a), 64'h1234);

    // ptr is 3: requesters 0/1 only, must wrap to 0
    rnd_a();
    cyc_a(4'b0011, 4'b0000);
    chk("wrap_src", 64'(src_a), 64'd0);
    rnd_a();
    cyc_a(4'b0011, 4'b0000);
    chk("wrap_next_src", 64'(src_a), 64'd1);

    for (int n = 0; n < 40; n++) begin
      rnd_a();
      cyc_a(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // asynchronous reset mid-stream
    req_a = 4'b1111;
    rst   = 1'b1;
    #2;
    chk("arst_q_a", 64'(q_a), 64'(RV));
    chk("arst_upd_a", 64'(upd_a), 64'd0);
    chk("arst_src_a", 64'(src_a), 64'd0);
    chk("arst_gnt_a", 64'(gnt_a), 64'b0001);
    ptr_a = 0; mq_a = RV; msrc_a = 0; sb_a.delete();
    ptr_b = 0; mq_b = '0; msrc_b = 0; sb_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      rnd_a();
      cyc_a(4'b1111, 4'b0000);
      chk("rot_src", 64'(src_a), 64'(k % 4));
    end

`ifdef DL_REG_WR_ARB_LOCK_EN
    for (int k = 0; k < 3; k++) begin
      rnd_a();
      cyc_a(4'b1010, 4'b0010);
      chk("lock_src", 64'(src_a), 64'd1);
    end
    rnd_a();
    cyc_a(4'b1010, 4'b0000);
    rnd_a();
    cyc_a(4'b1010, 4'b0000);
    chk("unlock_src", 64'(src_a), 64'd3);
`endif

    // three requesters: grants cycle 0,1,2,0,...
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 3; i++) wd_b[i] = $urandom;
      req_b = 3'b111;
      @(negedge clk);
      g = pick({5'b0, req_b}, ptr_b, 3);
      chk("gnt_b", 64'(gnt_b), 64'(3'(32'd1 << (k % 3))));
      if (g >= 0) begin
        mq_b   = wd_b[g[1:0]];
        msrc_b = g;
        ptr_b  = (g + 1) % 3;
      end
      sb_b.push_back('{mq_b, msrc_b, g >= 0});
      @(posedge clk); #1;
      e = sb_b.pop_front();
      chk("q_b", 64'(q_b), 64'(e.q));
      chk("src_b", 64'(src_b), 64'(e.src));
      chk("upd_b", 64'(upd_b), 64'(e.upd));
    end
    req_b = '0;
    req_a = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
